// File: rtl/csa_addsub_pipe.sv
// Two-stage pipelined carry-skip adder/subtractor with valid/ready handshakes.
// Stage 1 registers the operands with the subtract inversion already applied.
// Stage 2 registers the carry-skip result together with its status flags.
module csa_addsub_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NBLK = WIDTH / BLOCK;
  localparam int unsigned MSB  = WIDTH - 1;

  // Reject operand widths that cannot be tiled into whole skip blocks.
  if ((WIDTH % BLOCK) != 0) begin : g_width_not_multiple
    $error("csa_addsub_pipe: WIDTH must be a multiple of BLOCK");
  end
  if (WIDTH < 4) begin : g_width_too_small
    $error("csa_addsub_pipe: WIDTH must be at least 4");
  end

  // Stage 1 holds b and cin already inverted for subtract, so the mode bit
  // itself is not needed downstream and is not stored.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             adv2_c;
  logic             accept_c;
  logic [WIDTH-1:0] sum_raw_c;
  logic [NBLK:0]    blk_carry_c;

  // Handshake: stage 2 advances when empty or drained; stage 1 refills behind it.
  assign adv2_c   = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | adv2_c;
  assign accept_c = in_valid & in_ready;

  // Carry-skip chain: ripple inside each block, skip mux bypasses a fully propagating block.
  always_comb begin
    logic        rc;
    logic        prop;
    logic        x;
    int unsigned idx;
    rc          = 1'b0;
    prop        = 1'b0;
    x           = 1'b0;
    idx         = 0;
    sum_raw_c   = '0;
    blk_carry_c = '0;
    blk_carry_c[0] = c_q;
    for (int unsigned k = 0; k < NBLK; k++) begin
      rc   = blk_carry_c[k];
      prop = 1'b1;
      for (int unsigned j = 0; j < BLOCK; j++) begin
        idx            = k * BLOCK + j;
        x              = a_q[idx] ^ b_q[idx];
        sum_raw_c[idx] = x ^ rc;
        rc             = (a_q[idx] & b_q[idx]) | (x & rc);
        prop           = prop & x;
      end
      blk_carry_c[k+1] = prop ? blk_carry_c[k] : rc;
    end
  end

  // Stage 1 next state: take a new beat on accept, otherwise empty out when stage 2 advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    if (accept_c) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = sub ? ~b : b;
      c_d        = sub ? ~cin : cin;
    end else if (adv2_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: load result and flags on advance, hold everything while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (adv2_c) begin
      out_valid_d = s1_valid_q;
      sum_d       = sum_raw_c;
      cout_d      = blk_carry_c[NBLK];
      ovf_d       = (a_q[MSB] == b_q[MSB]) & (sum_raw_c[MSB] != a_q[MSB]);
      zero_d      = ~|sum_raw_c;
    end
  end

  // Pipeline registers; reset discards any in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
